// File: rtl/if_id_queue_pkg.sv
// Types and constants shared by the IF/ID instruction queue and the decode stage.
package if_id_queue_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'd0;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [WORD_W-1:0] pc,
                                                input logic [WORD_W-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push handshake and decode-side pop handshake of the IF/ID queue.
interface if_id_queue_if #(
    parameter int WORD_W = 32
);

    logic              in_valid;
    logic [WORD_W-1:0] in_pc;
    logic [WORD_W-1:0] in_instr;
    logic              in_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_pc;
    logic [WORD_W-1:0] out_instr;
    logic              out_ready;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/if_id_queue_fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for a power-of-2 circular buffer.
// Flush overrides both push and pop and rewinds everything to zero.
module fifo_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_req,
    input  logic          pop_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_en;

    // Full is judged on the registered count, so a full queue never takes a push
    // even if the head is popped in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_en   = push_req & ~full & ~flush;
    assign rd_en   = pop_req & ~empty & ~flush;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode; in_ready doubles as fetch's unfreeze.
// An empty queue presents a NOP with PC 0 to decode.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int WORD_W = if_id_queue_pkg::WORD_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    if_id_queue_if.slave  bus,
    output logic [CW-1:0] count
);

    logic [WORD_W-1:0] pc_mem    [DEPTH];
    logic [WORD_W-1:0] instr_mem [DEPTH];

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_req (bus.in_valid),
        .pop_req  (bus.out_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Storage is not reset; the empty-forcing below keeps stale words invisible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_addr]    <= bus.in_pc;
            instr_mem[wr_addr] <= bus.in_instr;
        end
    end

    always_comb begin
        bus.in_ready  = ~full;
        bus.out_valid = ~empty;
        bus.out_pc    = '0;
        bus.out_instr = WORD_W'(NOP_INSTR);
        if (!empty) begin
            bus.out_pc    = pc_mem[rd_addr];
            bus.out_instr = instr_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: vector table for per-cycle handshakes plus a queue
// model that supplies the expected head entry on every pop.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        out_ready;
        logic        flush;
        int          exp_count;
        logic        exp_out_valid;
        logic        exp_in_ready;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    if_id_queue_if #(.WORD_W(WORD_W)) bus ();

    if_id_queue #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    fetch_entry_t sb[$];
    vec_t         vecs[$];
    int           checks   = 0;
    int           failures = 0;

    function automatic vec_t mk(input logic v, input int pc, input logic rdy,
                                input logic fl, input int c, input logic ov, input logic ir);
        vec_t r;
        r.in_valid      = v;
        r.pc            = pc;
        r.instr         = (pc == 1) ? 32'hE3A00005 : (32'hE000_0000 | pc);
        r.out_ready     = rdy;
        r.flush         = fl;
        r.exp_count     = c;
        r.exp_out_valid = ov;
        r.exp_in_ready  = ir;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; compares pre-edge outputs against the model,
    // advances the model, then checks the post-edge table expectations.
    task automatic applyStimulus(input vec_t v, input int idx);
        fetch_entry_t head;
        bit           was_full;
        bus.in_valid  = v.in_valid;
        bus.in_pc     = v.pc;
        bus.in_instr  = v.instr;
        bus.out_ready = v.out_ready;
        flush         = v.flush;
        #1;
        checkOutput($sformatf("pre_out_valid[%0d]", idx), 64'(bus.out_valid), 64'(sb.size() != 0));
        checkOutput($sformatf("pre_count[%0d]", idx), 64'(count), 64'(sb.size()));
        if (sb.size() == 0) begin
            checkOutput($sformatf("nop_pc[%0d]", idx), 64'(bus.out_pc), 64'd0);
            checkOutput($sformatf("nop_instr[%0d]", idx), 64'(bus.out_instr), 64'd0);
        end
        was_full = (sb.size() == DEPTH);
        if (v.flush) begin
            sb.delete();
        end else begin
            if (v.out_ready && sb.size() != 0) begin
                head = sb.pop_front();
                checkOutput($sformatf("pop_pc[%0d]", idx), 64'(bus.out_pc), 64'(head.pc));
                checkOutput($sformatf("pop_instr[%0d]", idx), 64'(bus.out_instr), 64'(head.instr));
            end
            if (v.in_valid && !was_full) sb.push_back(make_entry(v.pc, v.instr));
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("count[%0d]", idx), 64'(count), 64'(v.exp_count));
        checkOutput($sformatf("out_valid[%0d]", idx), 64'(bus.out_valid), 64'(v.exp_out_valid));
        checkOutput($sformatf("in_ready[%0d]", idx), 64'(bus.in_ready), 64'(v.exp_in_ready));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1,  1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1,  1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1,  2, 0, 0, 2, 1, 1));
        vecs.push_back(mk(1,  3, 0, 0, 3, 1, 1));
        vecs.push_back(mk(1,  4, 0, 0, 4, 1, 0));
        vecs.push_back(mk(1,  5, 0, 0, 4, 1, 0));
        vecs.push_back(mk(1,  5, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1,  5, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1,  6, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1,  7, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1,  8, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1,  9, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1, 10, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 20, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 21, 0, 0, 2, 1, 1));
        vecs.push_back(mk(1, 22, 0, 0, 3, 1, 1));
        vecs.push_back(mk(0,  0, 1, 0, 2, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Asynchronous reset with two entries held, released away from any edge.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_rst_count", 64'(count), 64'd0);
        checkOutput("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("async_rst_out_instr", 64'(bus.out_instr), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(mk(1, 48, 0, 0, 1, 1, 1), 100);
        applyStimulus(mk(0,  0, 1, 0, 0, 0, 1), 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Small instruction queue between the instruction-fetch stage and the instruction-decode stage.
- Buffers {next-PC, instruction} pairs produced by fetch, so a decode-stage stall does not have to freeze fetch immediately.
- Discards all buffered entries when a taken branch resolves.
- Its in_ready drives fetch's freeze (freeze = ~in_ready). Its out_* signals replace the plain IF/ID pipeline register outputs.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- WORD_W, 32, width of the PC field and of the instruction field.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  branch taken; empties the queue.
- in_valid  input  1  fetch presents a valid entry.
- in_pc  input  WORD_W  fetch's incremented PC (PC+1).
- in_instr  input  WORD_W  fetched instruction word.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  WORD_W  PC field of the head entry.
- out_instr  output  WORD_W  instruction field of the head entry.
- out_ready  input  1  decode consumes the head this cycle (decode not stalled by a hazard).
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst low, asynchronous): rd_ptr=0, wr_ptr=0, count=0.
  - Outputs during and after reset: out_valid=0, out_pc=0, out_instr=0, in_ready=1.
  - Storage contents need not be cleared.
- Push occurs when in_valid & in_ready & ~flush.
  - Writes {in_pc, in_instr} at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Pop occurs when out_valid & out_ready & ~flush.
  - rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- in_ready = (count != DEPTH). It is purely combinational from count and does not depend on out_ready. A push into a full queue is therefore never accepted, even when a pop happens in the same cycle.
- out_valid = (count != 0). out_pc/out_instr are read combinationally from storage at rd_ptr.
  - When count==0, both are forced to 0 (NOP word).
- Latency: an entry pushed in cycle N appears on out_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- flush:
  - At the next edge, rd_ptr=wr_ptr=0 and count=0.
  - Same-cycle push and pop are both suppressed; flush wins.
  - out_valid=0 in the following cycle.
- in_valid while full: not accepted, and data is not lost, because fetch is frozen by ~in_ready and re-presents the same entry.
- out_ready while empty: ignored; no pointer movement.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). No partial entries remain.

Decomposition:
- Shared package contents:
  - WORD_W=32.
  - NOP_INSTR=32'd0.
  - A packed typedef fetch_entry_t {pc[WORD_W-1:0], instr[WORD_W-1:0]} (64 bits), also for reuse by the ID stage.
- One natural sub-module: fifo_ptr_ctrl.
  - Holds the pointer and count logic, plus push/pop qualification with flush.
  - Exports wr_en, wr_addr, rd_addr, full, empty and count.
- Storage is a register array inside if_id_queue.

Test Plan:
- Reset then idle: after rst deasserts, out_valid=0, in_ready=1, count=0, out_instr=0.
- Single push/pop:
  - Push in_pc=1, in_instr=32'hE3A00005 with out_ready=0; next cycle out_valid=1, out_pc=1, out_instr=32'hE3A00005, count=1.
  - Then out_ready=1 for one cycle; count=0.
- Fill and wrap:
  - Push PCs 1..4 with out_ready=0; count=4, in_ready=0.
  - An extra push of PC 5 is held, with count staying 4.
  - Then pop and push simultaneously for 6 cycles; out_pc sequence is 1,2,3,4,5,6 with no gaps or duplicates across the pointer wrap.
- Flush with simultaneous push and pop: with count=3, assert flush together with in_valid=1 and out_ready=1. Next cycle count=0, out_valid=0, and the pushed entry is absent.
- Full-queue simultaneous push and pop: with count=4, in_valid=1 and out_ready=1. Pop accepted, push rejected, count=3. in_ready=1 in the next cycle.
- Asynchronous reset mid-stream: with count=2, pull rst low between clock edges. out_valid drops to 0 and count to 0 before the next edge.
